// File: rtl/ir_convolver_pkg.sv
// ir_convolver_pkg: shared types, widths and saturation helper for the IR convolver.
package ir_convolver_pkg;
    typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, OUTPUT} state_e;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W = 48;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
    function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        return v > SAT_MAX ? SAMPLE_W'(SAT_MAX) : v < SAT_MIN ? SAMPLE_W'(SAT_MIN) : SAMPLE_W'(v);
    endfunction
endpackage

// File: rtl/ir_convolver_if.sv
// ir_convolver_if: audio, IR-capture and status signals of the convolver.
interface ir_convolver_if;
    import ir_convolver_pkg::*;
    logic                       audio_trigger;
    logic signed [SAMPLE_W-1:0] audio_in;
    logic                       ir_write_enable;
    logic                       ir_data_in_valid;
    logic [15:0]                ir_sample_index;
    logic signed [SAMPLE_W-1:0] ir_write_data;
    logic                       impulse_recorded;
    logic signed [SAMPLE_W-1:0] audio_out;
    logic                       audio_out_valid;
    logic                       ir_ready;
    logic                       busy;
    logic                       overrun;
    modport master (
        output audio_trigger, audio_in, ir_write_enable, ir_data_in_valid,
               ir_sample_index, ir_write_data, impulse_recorded,
        input  audio_out, audio_out_valid, ir_ready, busy, overrun
    );
    modport slave (
        input  audio_trigger, audio_in, ir_write_enable, ir_data_in_valid,
               ir_sample_index, ir_write_data, impulse_recorded,
        output audio_out, audio_out_valid, ir_ready, busy, overrun
    );
endinterface

// File: rtl/ir_coef_ram.sv
// ir_coef_ram: simple dual-port RAM, one write port and one registered read port (read-old on collision).
module ir_coef_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/ir_convolver.sv
// ir_convolver: one-MAC-per-clock FIR of live audio against a recorded impulse response.
module ir_convolver
    import ir_convolver_pkg::*;
#(
    parameter int TAPS      = 1024,
    parameter int ACC_SHIFT = 15
) (
    input logic           audio_clk,
    input logic           rst_in,
    ir_convolver_if.slave bus
);
    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
    localparam logic [SAMPLE_W:0] TAPS_W = (SAMPLE_W + 1)'(TAPS);
    state_e state_q, state_d;
    logic [AW-1:0] clr_q, clr_d, head_q, head_d, base_q, base_d, k_q, k_d;
    logic rd_v_q, prod_v_q, valid_q, ready_q, ready_d, overrun_q, overrun_d;
    logic signed [2*SAMPLE_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;
    logic clearing, accept, issue, emit, drop, busy, ir_wr;
    logic coef_we, hist_we;
    logic [AW-1:0] coef_waddr, hist_waddr, hist_raddr;
    logic [SAMPLE_W-1:0] coef_wdata, hist_wdata;
    logic signed [SAMPLE_W-1:0] coef_rdata, hist_rdata;

    ir_coef_ram #(.DEPTH(TAPS), .WIDTH(SAMPLE_W)) u_coef (
        .clk_i(audio_clk), .we_i(coef_we), .waddr_i(coef_waddr), .wdata_i(coef_wdata),
        .raddr_i(k_q), .rdata_o(coef_rdata)
    );
    ir_coef_ram #(.DEPTH(TAPS), .WIDTH(SAMPLE_W)) u_hist (
        .clk_i(audio_clk), .we_i(hist_we), .waddr_i(hist_waddr), .wdata_i(hist_wdata),
        .raddr_i(hist_raddr), .rdata_o(hist_rdata)
    );

    always_ff @(posedge audio_clk or posedge rst_in)
        if (rst_in) begin
            state_q   <= CLEAR;
            clr_q     <= '0;
            head_q    <= '0;
            base_q    <= '0;
            k_q       <= '0;
            rd_v_q    <= 1'b0;
            prod_v_q  <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            head_q    <= head_d;
            base_q    <= base_d;
            k_q       <= k_d;
            rd_v_q    <= issue;
            prod_v_q  <= rd_v_q;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            valid_q   <= emit;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end

    // DRAIN ends once the last read is in flight as a product; it lands in acc on that edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_q == LAST) state_d = IDLE;
            IDLE:    if (bus.audio_trigger) state_d = MAC;
            MAC:     if (k_q == LAST) state_d = DRAIN;
            DRAIN:   if (!rd_v_q) state_d = OUTPUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clearing   = state_q == CLEAR;
        accept     = state_q == IDLE && bus.audio_trigger;
        issue      = state_q == MAC;
        emit       = state_q == OUTPUT;
        busy       = state_q != IDLE;
        drop       = bus.audio_trigger && !clearing && busy;
        ir_wr      = !clearing && bus.ir_data_in_valid && bus.ir_write_enable &&
                     ({1'b0, bus.ir_sample_index} < TAPS_W);
        coef_we    = clearing || ir_wr;
        coef_waddr = clearing ? clr_q : bus.ir_sample_index[AW-1:0];
        coef_wdata = clearing ? '0 : bus.ir_write_data;
        hist_we    = clearing || accept;
        hist_waddr = clearing ? clr_q : head_q;
        hist_wdata = clearing ? '0 : bus.audio_in;
        hist_raddr = base_q - k_q;
    end

    always_comb begin
        clr_d     = clearing ? clr_q + AW'(1) : '0;
        head_d    = accept ? head_q + AW'(1) : head_q;
        base_d    = accept ? head_q : base_q;
        k_d       = issue ? k_q + AW'(1) : '0;
        prod_d    = (2*SAMPLE_W)'(coef_rdata) * (2*SAMPLE_W)'(hist_rdata);
        acc_d     = accept ? '0 : prod_v_q ? acc_q + ACC_W'(prod_q) : acc_q;
        out_d     = emit ? (ready_q ? sat(acc_q >>> ACC_SHIFT) : '0) : out_q;
        ready_d   = clearing ? ready_q : bus.impulse_recorded ? 1'b1 :
                    (ir_wr && bus.ir_sample_index == '0) ? 1'b0 : ready_q;
        overrun_d = overrun_q || drop;
    end

    assign bus.audio_out       = out_q;
    assign bus.audio_out_valid = valid_q;
    assign bus.ir_ready        = ready_q;
    assign bus.busy            = busy;
    assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_ir_convolver.sv
// tb_ir_convolver: random and directed stimulus against a behavioural convolution model.
module tb_ir_convolver;
    localparam int TAPS = 8;
    localparam int SHIFT = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ir_convolver_if bus();
    ir_convolver #(.TAPS(TAPS), .ACC_SHIFT(SHIFT)) dut (.audio_clk(clk), .rst_in(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { int due; int val; } exp_t;
    exp_t exp_q[$];
    int coef_m[TAPS];
    int hist_m[TAPS];
    int head_m, cyc, acc_c;
    bit have_acc, ready_m, overrun_m;
    int n_checks, n_err;

    task automatic chk(input string name, input longint act, input longint want);
        n_checks++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic bit busy_at(input int m);
        return m < TAPS || (have_acc && m > acc_c && m <= acc_c + TAPS + 3);
    endfunction

    function automatic int model_out();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(coef_m[k]) * hist_m[(head_m - k + TAPS) % TAPS];
        s = s >>> SHIFT;
        if (!ready_m) return 0;
        return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
    endfunction

    // Model: edge index cyc counts rising edges since reset release.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            cyc = 0; head_m = 0; have_acc = 0; ready_m = 0; overrun_m = 0;
            exp_q.delete();
            for (int i = 0; i < TAPS; i++) begin coef_m[i] = 0; hist_m[i] = 0; end
        end else begin
            if (cyc >= TAPS) begin
                if (bus.ir_data_in_valid && bus.ir_write_enable && bus.ir_sample_index < TAPS) begin
                    coef_m[bus.ir_sample_index] = bus.ir_write_data;
                    if (bus.ir_sample_index == 0 && !bus.impulse_recorded) ready_m = 0;
                end
                if (bus.impulse_recorded) ready_m = 1;
                if (bus.audio_trigger) begin
                    if (busy_at(cyc)) overrun_m = 1;
                    else begin
                        hist_m[head_m] = bus.audio_in;
                        exp_q.push_back('{cyc + TAPS + 4, model_out()});
                        head_m = (head_m + 1) % TAPS;
                        acc_c = cyc;
                        have_acc = 1;
                    end
                end
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("busy", bus.busy, busy_at(cyc));
            chk("overrun", bus.overrun, overrun_m);
            chk("ir_ready", bus.ir_ready, ready_m);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("out_valid", bus.audio_out_valid, 1);
                chk("audio_out", bus.audio_out, exp_q[0].val);
                void'(exp_q.pop_front());
            end else chk("no_valid", bus.audio_out_valid, 0);
        end
    end

    task automatic wr_coef(input int idx, input int val);
        @(negedge clk);
        bus.ir_data_in_valid = 1; bus.ir_write_enable = 1;
        bus.ir_sample_index = 16'(idx); bus.ir_write_data = 16'(val);
        @(negedge clk);
        bus.ir_data_in_valid = 0; bus.ir_write_enable = 0;
    endtask

    task automatic pulse_rec();
        @(negedge clk); bus.impulse_recorded = 1;
        @(negedge clk); bus.impulse_recorded = 0;
    endtask

    task automatic run_sample(input int x, output int y);
        int lat;
        @(negedge clk); bus.audio_trigger = 1; bus.audio_in = 16'(x);
        @(negedge clk); bus.audio_trigger = 0;
        lat = 1;
        while (!bus.audio_out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("latency", lat, TAPS + 4);
        y = bus.audio_out;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int y, nb, vc;
        bus.audio_trigger = 0; bus.audio_in = 0; bus.ir_write_enable = 0; bus.ir_data_in_valid = 0;
        bus.ir_sample_index = 0; bus.ir_write_data = 0; bus.impulse_recorded = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1);
        chk("rst_valid", bus.audio_out_valid, 0);
        rst = 0;
        nb = bus.busy;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            bus.audio_trigger = (i == 1); bus.audio_in = 777;
        end
        chk("clear_busy_cycles", nb, 8);
        chk("clear_trigger_no_overrun", bus.overrun, 0);
        run_sample(1234, y); chk("first_out_zero", y, 0);
        // identity: coef0 = 32767
        wr_coef(0, 32767); pulse_rec();
        chk("ready_after_record", bus.ir_ready, 1);
        run_sample(1000, y); chk("identity_pos", y, 999);
        run_sample(-500, y); chk("identity_neg", y, -500);
        wr_coef(0, 16384);
        chk("ready_cleared_idx0", bus.ir_ready, 0);
        wr_coef(1, 16384); pulse_rec();
        run_sample(2000, y); chk("half_sum_a", y, 750);
        run_sample(4000, y); chk("half_sum_b", y, 3000);
        for (int i = 0; i < TAPS; i++) wr_coef(i, 32767);
        pulse_rec();
        repeat (TAPS) run_sample(32767, y);
        chk("sat_pos", y, 32767);
        repeat (TAPS) run_sample(-32767, y);
        chk("sat_neg", y, -32768);
        // second trigger 5 cycles after the first is dropped
        @(negedge clk); bus.audio_trigger = 1; bus.audio_in = 111;
        @(negedge clk); bus.audio_trigger = 0;
        repeat (4) @(negedge clk);
        bus.audio_trigger = 1; bus.audio_in = 222;
        @(negedge clk); bus.audio_trigger = 0;
        repeat (TAPS + 10) @(negedge clk);
        chk("overrun_set", bus.overrun, 1);
        run_sample(10, y);
        chk("overrun_held", bus.overrun, 1);
        wr_coef(9, 4321);
        chk("oob_write_keeps_ready", bus.ir_ready, 1);
        wr_coef(0, 0);
        chk("ready_dropped", bus.ir_ready, 0);
        run_sample(5000, y); chk("not_ready_out_zero", y, 0);
        pulse_rec();
        @(negedge clk); bus.audio_trigger = 1; bus.audio_in = 300;
        @(negedge clk); bus.audio_trigger = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_out", bus.audio_out, 0);
        chk("async_rst_valid", bus.audio_out_valid, 0);
        chk("async_rst_ready", bus.ir_ready, 0);
        chk("async_rst_busy", bus.busy, 1);
        chk("async_rst_overrun", bus.overrun, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        vc = 0;
        repeat (2 * TAPS + 10) begin @(negedge clk); if (bus.audio_out_valid) vc++; end
        chk("no_valid_after_reset", vc, 0);
        for (int r = 0; r < 6; r++) begin
            repeat (8) wr_coef($urandom_range(0, 11), $urandom);
            if ($urandom_range(0, 3) != 0) pulse_rec();
            repeat (15) begin
                @(negedge clk); bus.audio_trigger = 1; bus.audio_in = 16'($urandom);
                @(negedge clk); bus.audio_trigger = 0;
                repeat ($urandom_range(0, 14)) @(negedge clk);
            end
            repeat (TAPS + 8) @(negedge clk);
        end
        chk("pending_outputs", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
